// File: rtl/psram_pkg.sv
// Shared encodings and default sizing for the PSRAM access arbiter.
package psram_pkg;

  localparam int unsigned FIFO_DEPTH_DEF  = 512;
  localparam int unsigned BURST_WORDS_DEF = 32;
  localparam int unsigned MAX_RD_RUN_DEF  = 4;
  localparam int unsigned ADDR_W          = 22;
  localparam int unsigned USEDW_W         = 10;
  localparam int unsigned SPACE_W         = 11;

  typedef enum logic [1:0] {
    OP_REFILL     = 2'd0,
    OP_QUAD_EXIT  = 2'd1,
    OP_QUAD_ENTER = 2'd2
  } eng_op_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_WAIT    = 3'd1,
    ST_EXIT_WAIT  = 3'd2,
    ST_MCU_OWN    = 3'd3,
    ST_ENTER_WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/psram_access_arbiter.sv
// Shares the PSRAM pins between the read-FIFO refill engine and the MCU bus,
// bounding refill bursts while the MCU waits and bracketing MCU ownership with quad exit/enter.
module psram_access_arbiter
  import psram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned BURST_WORDS = BURST_WORDS_DEF,
  parameter int unsigned MAX_RD_RUN  = MAX_RD_RUN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [USEDW_W-1:0] fifo_wrusedw,
  input  logic               fifo_full,
  input  logic               mcu_req,
  input  logic               eng_done,
  output logic               eng_start,
  output logic [1:0]         eng_op,
  output logic [ADDR_W-1:0]  eng_addr,
  output logic               mcu_grant,
  output logic               pin_owner
);

  localparam int unsigned RUN_W = $clog2(MAX_RD_RUN + 1);

  state_e              state_q, state_d;
  logic                eng_start_q, eng_start_d;
  eng_op_e             eng_op_q, eng_op_d;
  logic [ADDR_W-1:0]   eng_addr_q, eng_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic                mcu_grant_q, mcu_grant_d;
  logic                pin_owner_q, pin_owner_d;

  logic [SPACE_W-1:0]  space_c;
  logic                refill_ok_c;
  logic                run_at_max_c;

  // Free FIFO words; a burst is only worth issuing when it fits entirely.
  assign space_c      = SPACE_W'(FIFO_DEPTH) - SPACE_W'(fifo_wrusedw);
  assign refill_ok_c  = (space_c >= SPACE_W'(BURST_WORDS)) && !fifo_full;
  assign run_at_max_c = (run_cnt_q == RUN_W'(MAX_RD_RUN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      eng_start_q <= 1'b0;
      eng_op_q    <= OP_REFILL;
      eng_addr_q  <= '0;
      rd_addr_q   <= '0;
      run_cnt_q   <= '0;
      mcu_grant_q <= 1'b0;
      pin_owner_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      eng_start_q <= eng_start_d;
      eng_op_q    <= eng_op_d;
      eng_addr_q  <= eng_addr_d;
      rd_addr_q   <= rd_addr_d;
      run_cnt_q   <= run_cnt_d;
      mcu_grant_q <= mcu_grant_d;
      pin_owner_q <= pin_owner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    eng_start_d = 1'b0;
    eng_op_d    = eng_op_q;
    eng_addr_d  = eng_addr_q;
    rd_addr_d   = rd_addr_q;
    run_cnt_d   = run_cnt_q;
    mcu_grant_d = mcu_grant_q;
    pin_owner_d = pin_owner_q;

    case (state_q)
      ST_IDLE: begin
        if (!mcu_req) begin
          run_cnt_d = '0;
        end
        // Refill wins unless the MCU has already waited out a full run of bursts.
        if (refill_ok_c && !(mcu_req && run_at_max_c)) begin
          eng_start_d = 1'b1;
          eng_op_d    = OP_REFILL;
          eng_addr_d  = rd_addr_q;
          state_d     = ST_RD_WAIT;
        end else if (mcu_req) begin
          eng_start_d = 1'b1;
          eng_op_d    = OP_QUAD_EXIT;
          state_d     = ST_EXIT_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (eng_done) begin
          rd_addr_d = rd_addr_q + ADDR_W'(BURST_WORDS);
          if (mcu_req && !run_at_max_c) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
          end
          state_d = ST_IDLE;
        end
      end
      ST_EXIT_WAIT: begin
        if (eng_done) begin
          mcu_grant_d = 1'b1;
          pin_owner_d = 1'b0;
          run_cnt_d   = '0;
          state_d     = ST_MCU_OWN;
        end
      end
      ST_MCU_OWN: begin
        // Pins go back to the engine in the same cycle the quad-enter launches.
        if (!mcu_req) begin
          mcu_grant_d = 1'b0;
          pin_owner_d = 1'b1;
          eng_start_d = 1'b1;
          eng_op_d    = OP_QUAD_ENTER;
          state_d     = ST_ENTER_WAIT;
        end
      end
      ST_ENTER_WAIT: begin
        if (eng_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign eng_start = eng_start_q;
  assign eng_op    = eng_op_q;
  assign eng_addr  = eng_addr_q;
  assign mcu_grant = mcu_grant_q;
  assign pin_owner = pin_owner_q;

endmodule

// File: doc/psram_access_arbiter.md
PSRAM_ACCESS_ARBITER -- requirements
Module: psram_access_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 512, read-FIFO capacity in words.
REQ-002 SHALL have parameter BURST_WORDS, 32, words per refill burst; also the address increment.
REQ-003 SHALL have parameter MAX_RD_RUN, 4, maximum consecutive refill bursts while MCU request pending.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port fifo_wrusedw  in  10  read-FIFO write-side fill level.
REQ-007 SHALL have port fifo_full  in  1  read-FIFO full flag.
REQ-008 SHALL have port mcu_req  in  1  MCU bus request, already synchronized to clk; level.
REQ-009 SHALL have port eng_done  in  1  one-cycle pulse; engine finished current operation.
REQ-010 SHALL have port eng_start  out  1  one-cycle pulse; launch engine operation.
REQ-011 SHALL have port eng_op  out  2  operation: 0 refill burst read, 1 quad-mode exit, 2 quad-mode enter.
REQ-012 SHALL have port eng_addr  out  22  refill burst start address; valid when eng_start=1 and eng_op=0.
REQ-013 SHALL have port mcu_grant  out  1  high while MCU owns PSRAM pins.
REQ-014 SHALL have port pin_owner  out  1  pin mux select: 1 engine, 0 MCU.

Function
REQ-015 SHALL implement states IDLE, RD_WAIT, EXIT_WAIT, MCU_OWN, ENTER_WAIT.
REQ-016 SHALL define space = FIFO_DEPTH - fifo_wrusedw, computed at 11 bits; refill_ok = (space >= BURST_WORDS) and not fifo_full.
REQ-017 In IDLE SHALL select in priority order: refill if refill_ok and not (mcu_req and run_cnt == MAX_RD_RUN); otherwise quad exit if mcu_req; otherwise remain idle.
REQ-018 Refill selection SHALL assert eng_start one cycle with eng_op=0, eng_addr=rd_addr, enter RD_WAIT.
REQ-019 Exit selection SHALL assert eng_start one cycle with eng_op=1, enter EXIT_WAIT.
REQ-020 RD_WAIT on eng_done SHALL advance rd_addr by BURST_WORDS modulo 2^22, increment run_cnt (saturating at MAX_RD_RUN) if mcu_req is high, and return to IDLE.
REQ-021 run_cnt SHALL clear whenever mcu_req is low in IDLE and upon entering MCU_OWN.
REQ-022 EXIT_WAIT on eng_done SHALL enter MCU_OWN the next cycle, driving pin_owner=0 and mcu_grant=1 from that cycle.
REQ-023 MCU_OWN SHALL hold until mcu_req is low; then it SHALL drop mcu_grant, set pin_owner=1, pulse eng_start with eng_op=2, and enter ENTER_WAIT in the same cycle.
REQ-024 ENTER_WAIT on eng_done SHALL return to IDLE; no new operation SHALL start before that.
REQ-025 eng_done in IDLE or MCU_OWN SHALL be ignored.
REQ-026 eng_start SHALL never assert on two consecutive cycles; at most one operation SHALL be outstanding.
REQ-027 Refill SHALL never be issued while mcu_grant=1, even if the FIFO drains empty.
REQ-028 Decision latency SHALL be one cycle: a condition sampled in IDLE produces eng_start on the next rising edge.

Reset
REQ-029 Reset SHALL force state=IDLE, eng_start=0, eng_op=0, eng_addr=0, rd_addr=0, run_cnt=0, mcu_grant=0, pin_owner=1.
REQ-030 Reset asserted mid-operation SHALL abandon it immediately; no eng_start SHALL occur while reset is high.

Structure
REQ-031 SHALL place the eng_op encodings, the state encoding, and FIFO_DEPTH/BURST_WORDS defaults in shared package psram_pkg.
REQ-032 SHALL be a single module with no sub-modules; synchronizers and the engine stay external.

Verification
REQ-033 Empty FIFO (wrusedw=0), mcu_req=0 -> eng_start with op0, addr 0; after done, next burst addr 32; at wrusedw=481, no issue.
REQ-034 rd_addr=0x3FFFE0, burst done -> next eng_addr=0x000000 (wrap).
REQ-035 Constant refill_ok, mcu_req held high, MAX_RD_RUN=4 -> exactly 4 refill bursts, then op1, then mcu_grant=1 one cycle after done.
REQ-036 In MCU_OWN, drop mcu_req at cycle T -> at edge T+1: mcu_grant=0, pin_owner=1, eng_start with op2; return to IDLE one cycle after done.
REQ-037 FIFO drained to 0 during MCU_OWN -> no eng_start until ENTER_WAIT completes; spurious eng_done in MCU_OWN has no effect.
REQ-038 Assert reset during RD_WAIT -> all outputs reach reset values; rd_addr=0; first post-reset burst address is 0.
